// File: rtl/bitops_lo_iter_pkg.sv
// Shared definitions for the set-bit iterator and its lowest-bit helper.
// Holds the FSM state encoding and the default mask/index widths.
package bitops_lo_iter_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_IDX_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/bitops_lo_iter_get_lo.sv
// Combinational lowest-set-bit isolator with a one-hot to binary index encoder.
// Reusable on its own; an all-zero input yields onehot = 0 and idx = 0.
module bitops_get_lo import bitops_lo_iter_pkg::*; #(
  parameter int width     = DEF_WIDTH,
  parameter int idx_width = DEF_IDX_WIDTH
) (
  input  logic [width-1:0]     vec,
  output logic [width-1:0]     onehot,
  output logic [idx_width-1:0] idx
);

  // Two's complement trick keeps only the lowest set bit of the input
  always_comb begin
    onehot = vec & (~vec + width'(1));
  end

  // OR-reduce the positions of set bits; with a one-hot input this is its index
  always_comb begin
    idx = '0;
    for (int i = 0; i < width; i++) begin
      if (onehot[i]) begin
        idx = idx | idx_width'(i);
      end
    end
  end

endmodule

// File: rtl/bitops_lo_iter.sv
// Sequential set-bit iterator: loads a mask and hands out its set bits,
// lowest index first, over a valid/ready handshake, then pulses done.
// Optional macro BITOPS_LO_ITER_COUNT_EN adds out_count, the number of
// items transferred so far in the current iteration.
module bitops_lo_iter import bitops_lo_iter_pkg::*; #(
  parameter int width     = DEF_WIDTH,
  parameter int idx_width = DEF_IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [width-1:0]     in,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width-1:0]     out_onehot,
  output logic [idx_width-1:0] out_idx,
  output logic                 out_last,
  output logic                 done
`ifdef BITOPS_LO_ITER_COUNT_EN
  ,output logic [idx_width:0]  out_count
`endif
);

  state_t state;
  state_t state_next;

  logic [width-1:0]     resid;
  logic [width-1:0]     rest;
  logic [width-1:0]     lo_onehot;
  logic [idx_width-1:0] lo_idx;
  logic                 accept_start;
  logic                 xfer;
  logic                 is_last;

  bitops_get_lo #(
    .width     (width),
    .idx_width (idx_width)
  ) u_get_lo (
    .vec    (resid),
    .onehot (lo_onehot),
    .idx    (lo_idx)
  );

  // Handshake qualifiers and the residue left once the current bit is consumed
  always_comb begin
    accept_start = (state == ST_IDLE) && start;
    xfer         = (state == ST_SCAN) && out_ready;
    rest         = resid & (resid - width'(1));
    is_last      = (rest == '0);
  end

  // State register; reset drops straight to IDLE with no done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: an empty mask skips SCAN, the last transfer leads to FIN
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (in != '0) ? ST_SCAN : ST_FIN;
        end
      end
      ST_SCAN: begin
        if (xfer && is_last) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Residue register: loaded on accepted start, lowest bit cleared per transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resid <= '0;
    end else if (accept_start) begin
      resid <= in;
    end else if (xfer) begin
      resid <= rest;
    end
  end

  // Outputs: item fields only during SCAN, zero elsewhere
  always_comb begin
    busy       = 1'b0;
    out_valid  = 1'b0;
    out_onehot = '0;
    out_idx    = '0;
    out_last   = 1'b0;
    done       = 1'b0;
    case (state)
      ST_SCAN: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        out_onehot = lo_onehot;
        out_idx    = lo_idx;
        out_last   = is_last;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef BITOPS_LO_ITER_COUNT_EN
  // Transfer counter: cleared on accepted start, holds through FIN and IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_count <= '0;
    end else if (accept_start) begin
      out_count <= '0;
    end else if (xfer) begin
      out_count <= out_count + (idx_width + 1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bitops_lo_iter.sv
// Self-checking bench for bitops_lo_iter: directed scenarios followed by
// randomized masks and ready patterns, compared against a queue-based model.
module tb_bitops_lo_iter;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  in;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_onehot;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          done;
`ifdef BITOPS_LO_ITER_COUNT_EN
  logic [IW:0]   out_count;
`endif

  int numChecks = 0;
  int numFails  = 0;

  // Model: pending indices in ascending order, phase 0 idle / 1 scan / 2 fin
  int q[$];
  int phase = 0;
  int cnt   = 0;

  bitops_lo_iter #(.width(W), .idx_width(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in         (in),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .done       (done)
`ifdef BITOPS_LO_ITER_COUNT_EN
    ,.out_count (out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Compare every output against what the model says this cycle should show
  task automatic checkAll(input string tag);
    logic [31:0] expOnehot;
    expOnehot = 0;
    if (phase == 1) expOnehot = 32'd1 << q[0];
    checkOutput({tag, ".busy"},   32'(busy),      32'(phase == 1));
    checkOutput({tag, ".valid"},  32'(out_valid), 32'(phase == 1));
    checkOutput({tag, ".onehot"}, 32'(out_onehot), expOnehot);
    checkOutput({tag, ".idx"},    32'(out_idx),   (phase == 1) ? 32'(q[0]) : 32'd0);
    checkOutput({tag, ".last"},   32'(out_last),  32'((phase == 1) && (q.size() == 1)));
    checkOutput({tag, ".done"},   32'(done),      32'(phase == 2));
`ifdef BITOPS_LO_ITER_COUNT_EN
    checkOutput({tag, ".count"},  32'(out_count), 32'(cnt));
`endif
  endtask

  // One clock: check at the falling edge, drive inputs, advance the model
  task automatic applyStimulus(input string tag, input logic st, input logic [W-1:0] m, input logic rdy);
    @(negedge clk);
    checkAll(tag);
    start     = st;
    in        = m;
    out_ready = rdy;
    case (phase)
      1: begin
        if (rdy) begin
          void'(q.pop_front());
          cnt++;
          if (q.size() == 0) phase = 2;
        end
      end
      2: phase = 0;
      default: begin
        if (st) begin
          cnt = 0;
          if (m == 0) begin
            phase = 2;
          end else begin
            for (int i = 0; i < W; i++) if (m[i]) q.push_back(i);
            phase = 1;
          end
        end
      end
    endcase
  endtask

  // Keep ready high until the model returns to idle, bounded
  task automatic drain(input string tag);
    for (int i = 0; i < 40 && phase != 0; i++) applyStimulus(tag, 1'b0, '0, 1'b1);
    applyStimulus(tag, 1'b0, '0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in = '0;
    out_ready = 1'b0;
    #12;
    checkAll("reset");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("idle", 1'b0, '0, 1'b0);

    applyStimulus("a4", 1'b1, 8'hA4, 1'b1);
    drain("a4");

    applyStimulus("zero", 1'b1, 8'h00, 1'b1);
    drain("zero");

    applyStimulus("hold", 1'b1, 8'h12, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("hold", 1'b0, '0, 1'b0);
    drain("hold");

    applyStimulus("restart", 1'b1, 8'h94, 1'b1);
    applyStimulus("restart", 1'b1, 8'hFF, 1'b1);
    applyStimulus("restart", 1'b1, 8'hFF, 1'b0);
    drain("restart");

    applyStimulus("c1", 1'b1, 8'hC1, 1'b1);
    drain("c1");
    applyStimulus("c1hold", 1'b0, '0, 1'b0);

    applyStimulus("rstmid", 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("rstmid", 1'b0, '0, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    phase = 0;
    cnt = 0;
    checkAll("rstnow");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("after", 1'b0, '0, 1'b1);
    applyStimulus("after", 1'b1, 8'hFF, 1'b1);
    drain("after");

    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] m;
      logic [2:0] sel;
      sel = 3'($urandom_range(0, 7));
      m = W'($urandom);
      if (sel == 0) m = '0;
      if (sel == 1) m = '1;
      applyStimulus("rand", 1'($urandom_range(0, 3) == 0), m, 1'($urandom_range(0, 2) != 0));
    end
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end

endmodule
